nibble_serial_adder: RTL and testbench



---
 rtl/nsa_pkg.sv | 12 +
 rtl/nibble_adder4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared state encodings and nibble width for nibble_serial_adder
package nsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_adder4.sv
// rtl/nibble_adder4.sv - combinational 4-bit ripple-carry slice exposing every bit carry
module nibble_adder4
   import nsa_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic [NIB_W-1:0] co
);

   logic c;

   always_comb begin
      c  = cin;
      s  = '0;
      co = '0;
      for (int i = 0; i < NIB_W; i++) begin
         s[i]  = x[i] ^ y[i] ^ c;
         co[i] = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
         c     = co[i];
      end
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder run one nibble per clock through a shared slice
// Defining NIBBLE_SERIAL_ADDER_OVF_EN enables the registered signed-overflow flag.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = $clog2(NIB);
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               c_out_q, c_out_d;
   logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;

   logic [NIB_W-1:0]   slice_s;
   logic [NIB_W-1:0]   slice_co;
   logic [WIDTH-1:0]   sum_shifted;
   logic               unused_co;

   nibble_adder4 u_slice (
      .x   (a_sh_q[NIB_W-1:0]),
      .y   (b_sh_q[NIB_W-1:0]),
      .cin (carry_q),
      .s   (slice_s),
      .co  (slice_co)
   );

   // Each nibble enters at the top, so after NIB shifts nibble 0 sits at the bottom.
   assign sum_shifted = {slice_s, sum_sh_q[WIDTH-1:NIB_W]};
   assign unused_co   = ^slice_co[1:0];

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      sum_sh_d  = sum_sh_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      c_out_d   = c_out_q;
      nib_cnt_d = nib_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d    = a;
               b_sh_d    = b;
               carry_d   = c_in;
               nib_cnt_d = '0;
               state_d   = ADD;
            end
         end
         ADD: begin
            carry_d   = slice_co[NIB_W-1];
            sum_sh_d  = sum_shifted;
            a_sh_d    = a_sh_q >> NIB_W;
            b_sh_d    = b_sh_q >> NIB_W;
            nib_cnt_d = nib_cnt_q + CNT_W'(1);
            if (nib_cnt_q == LAST_NIB) begin
               sum_d   = sum_shifted;
               c_out_d = slice_co[NIB_W-1];
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         sum_sh_q  <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         c_out_q   <= 1'b0;
         nib_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         sum_sh_q  <= sum_sh_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         c_out_q   <= c_out_d;
         nib_cnt_q <= nib_cnt_d;
      end
   end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == ADD && nib_cnt_q == LAST_NIB) begin
         ovf_d = slice_co[NIB_W-1] ^ slice_co[NIB_W-2];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   logic unused_co2;
   assign unused_co2 = slice_co[NIB_W-2];
   assign ovf        = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign sum       = sum_q;
   assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and random checks of nibble_serial_adder against an arithmetic model
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk;
   logic             resetn;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   int vectors;
   int miscompares;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Whole-word reference: unsigned add for sum/carry, sign rule for overflow.
   task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                        output logic [WIDTH-1:0] s, output logic co, output logic ov);
      logic [WIDTH:0] full;
      full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
      s    = full[WIDTH-1:0];
      co   = full[WIDTH];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ov   = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
`else
      ov   = 1'b0;
`endif
   endtask

   // Offer operands at a negedge, accept on the next posedge, then count edges until out_valid.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic consume);
      logic [WIDTH-1:0] es;
      logic             ec;
      logic             eo;
      int               edges;
      model(x, y, ci, es, ec, eo);
      a        = x;
      b        = y;
      c_in     = ci;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " in_ready_low"}, in_ready, 1'b0);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      check({tag, " latency"}, edges, NIB);
      check({tag, " out_valid"}, out_valid, 1'b1);
      check({tag, " sum"}, sum, es);
      check({tag, " c_out"}, c_out, ec);
      check({tag, " ovf"}, ovf, eo);
      if (consume) begin
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         check({tag, " back_idle"}, in_ready, 1'b1);
         check({tag, " sum_kept"}, sum, es);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] es;
      logic             ec;
      logic             eo;
      logic             saw_valid;
      vectors     = 0;
      miscompares = 0;
      resetn      = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      a           = '0;
      b           = '0;
      c_in        = 1'b0;
      repeat (3) @(negedge clk);
      check("reset in_ready", in_ready, 1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset sum", sum, 0);
      check("reset c_out", c_out, 1'b0);
      check("reset ovf", ovf, 1'b0);
      resetn = 1'b1;
      @(negedge clk);

      run_op("d1234", 16'h1234, 16'h4321, 1'b0, 1'b1);
      run_op("dffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      run_op("d7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
      run_op("dffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      run_op("d8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      end

      // Backpressure with new operands waiting during HOLD.
      run_op("bp", 16'hABCD, 16'h1111, 1'b0, 1'b0);
      model(16'hABCD, 16'h1111, 1'b0, es, ec, eo);
      a        = 16'h0001;
      b        = 16'h0001;
      c_in     = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp hold sum %0d", i), sum, es);
         check($sformatf("bp hold in_ready %0d", i), in_ready, 1'b0);
         check($sformatf("bp hold out_valid %0d", i), out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("bp idle in_ready", in_ready, 1'b1);
      run_op("bp next", 16'h0001, 16'h0001, 1'b0, 1'b1);

      // Reset during the second ADD cycle.
      run_op("pre_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b1);
      a        = 16'h1111;
      b        = 16'h2222;
      c_in     = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("abort out_valid", out_valid, 1'b0);
      check("abort in_ready", in_ready, 1'b1);
      check("abort sum", sum, 0);
      repeat (2) @(negedge clk);
      resetn    = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("abort no out_valid", saw_valid, 1'b0);
      check("abort idle in_ready", in_ready, 1'b1);
      check("abort idle sum", sum, 0);
      check("abort idle c_out", c_out, 1'b0);

      run_op("post_abort", 16'h1111, 16'h2222, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
